// File: rtl/bounce_addr_gen.sv
// Bouncing sprite origin plus image-ROM address generator.
// Consumes the VGA timer position, moves the sprite origin once per frame
// during vertical blanking, and registers the ROM read address and in-sprite
// qualifier so they line up with the ROM's one-cycle read latency.
module bounce_addr_gen #(
    parameter int SCREEN_WIDTH   = 640,
    parameter int SCREEN_HEIGHT  = 480,
    parameter int IMAGE_WIDTH    = 160,
    parameter int IMAGE_HEIGHT   = 120,
    parameter int IMAGE_ROM_SIZE = IMAGE_WIDTH * IMAGE_HEIGHT,
    parameter int STEP_X         = 1,
    parameter int STEP_Y         = 1,
    localparam int AW            = $clog2(IMAGE_ROM_SIZE)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic [9:0]    position_x_i,
    input  logic [9:0]    position_y_i,
    input  logic          visible_i,
    input  logic          pause_i,
    output logic [AW-1:0] rom_addr_o,
    output logic          in_sprite_o,
    output logic          valid_o,
    output logic [9:0]    sprite_x_o,
    output logic [9:0]    sprite_y_o
);

    // Limits and sizes held at 11 bits so edge sums never wrap.
    localparam logic [10:0] MAX_X   = 11'(SCREEN_WIDTH - IMAGE_WIDTH);
    localparam logic [10:0] MAX_Y   = 11'(SCREEN_HEIGHT - IMAGE_HEIGHT);
    localparam logic [10:0] STEP_X1 = 11'(STEP_X);
    localparam logic [10:0] STEP_Y1 = 11'(STEP_Y);
    localparam logic [10:0] IMG_W   = 11'(IMAGE_WIDTH);
    localparam logic [10:0] IMG_H   = 11'(IMAGE_HEIGHT);
    localparam logic [9:0]  TICK_Y  = 10'(SCREEN_HEIGHT);

    // One axis of bounce motion; returns {dir, position} after a step.
    // Clamps at the edge and flips direction on the same step.
    function automatic logic [10:0] step_axis(
        input logic [9:0]  pos,
        input logic        dir,
        input logic [10:0] step,
        input logic [10:0] maxv
    );
        logic [10:0] sum;
        sum = {1'b0, pos} + step;
        if (!dir) begin
            if (sum >= maxv) return {1'b1, maxv[9:0]};
            else             return {1'b0, sum[9:0]};
        end else begin
            if ({1'b0, pos} <= step) return {1'b0, 10'd0};
            else                     return {1'b1, pos - step[9:0]};
        end
    endfunction

    logic [9:0]    sprite_x, sprite_y;
    logic          dir_x, dir_y;
    logic          tick_cond_p0, tick_cond_p1, tick_p0;
    logic [10:0]   next_x_p0, next_y_p0;
    logic          hit_p0;
    logic [9:0]    dx_p0, dy_p0;
    logic [AW-1:0] addr_p0;

    // Stage p0: frame tick detect, next origin, hit test and address
    always_comb begin
        tick_cond_p0 = (position_x_i == 10'd0) && (position_y_i == TICK_Y);
        tick_p0      = tick_cond_p0 && !tick_cond_p1;
        next_x_p0    = step_axis(sprite_x, dir_x, STEP_X1, MAX_X);
        next_y_p0    = step_axis(sprite_y, dir_y, STEP_Y1, MAX_Y);
        hit_p0       = visible_i
                    && ({1'b0, position_x_i} >= {1'b0, sprite_x})
                    && ({1'b0, position_x_i} <  ({1'b0, sprite_x} + IMG_W))
                    && ({1'b0, position_y_i} >= {1'b0, sprite_y})
                    && ({1'b0, position_y_i} <  ({1'b0, sprite_y} + IMG_H));
        dx_p0        = position_x_i - sprite_x;
        dy_p0        = position_y_i - sprite_y;
        // Modular arithmetic: truncating the full-width result equals
        // computing directly at AW bits.
        addr_p0      = hit_p0 ? AW'(AW'(dy_p0) * AW'(IMAGE_WIDTH) + AW'(dx_p0)) : '0;
    end

    // Sprite origin and direction move once per frame unless paused
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sprite_x <= '0;
            sprite_y <= '0;
            dir_x    <= 1'b0;
            dir_y    <= 1'b0;
        end else if (tick_p0 && !pause_i) begin
            {dir_x, sprite_x} <= next_x_p0;
            {dir_y, sprite_y} <= next_y_p0;
        end
    end

    // Tick-condition history so a held tick position steps only once
    always_ff @(posedge clk_i) begin
        if (!rst_ni) tick_cond_p1 <= 1'b0;
        else         tick_cond_p1 <= tick_cond_p0;
    end

    // Stage p1/p2: registered address, qualifier, and ROM-data-aligned valid
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rom_addr_o  <= '0;
            in_sprite_o <= 1'b0;
            valid_o     <= 1'b0;
        end else begin
            rom_addr_o  <= addr_p0;
            in_sprite_o <= hit_p0;
            valid_o     <= in_sprite_o;
        end
    end

    assign sprite_x_o = sprite_x;
    assign sprite_y_o = sprite_y;

endmodule
